// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  // The pc field is kept at full 32 bits so the entry type does not depend on
  // the ROM address width. The top zero-extends on push and truncates on read.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam int PC_STEP = 4;

endpackage

// File: rtl/fetch_fifo.sv
// Circular FIFO of fetch entries. Flush empties it and wins over push/pop.
// Contents are zeroed on reset so the head reads as zero until the first push.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  fetch_entry_t mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // Pointer/occupancy bookkeeping and storage writes; pointers wrap naturally
  // because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, drives the ROM address,
// buffers fetched words and presents them to decode over valid/ready.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 12,
  parameter int RESET_PC      = 0,
  parameter int DEPTH         = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic [ADDRESS_WIDTH-1:0] rom_addr,
  input  logic [31:0]              rom_instr,
  input  logic                     halt_i,
  input  logic                     redirect_i,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc_i,
  output logic [31:0]              instr_o,
  output logic [ADDRESS_WIDTH-1:0] pc_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic                     misalign_o
);

  fetch_state_t             state_reg;
  logic [ADDRESS_WIDTH-1:0] fetch_pc_reg;
  logic                     misalign_reg;

  logic         fifo_full;
  logic         fifo_empty;
  fetch_entry_t fifo_head;
  fetch_entry_t fifo_din;
  logic         pop;
  logic         push;

  // A popped word is delivered even when a redirect flushes in the same cycle;
  // a redirect suppresses the push so the stale sequential word never lands.
  assign pop  = valid_o & ready_i;
  assign push = (state_reg == RUN) & ~redirect_i & (~fifo_full | pop);

  assign fifo_din.pc    = 32'(fetch_pc_reg);
  assign fifo_din.instr = rom_instr;

  assign rom_addr   = fetch_pc_reg;
  assign valid_o    = ~fifo_empty;
  assign instr_o    = fifo_head.instr;
  assign pc_o       = fifo_head.pc[ADDRESS_WIDTH-1:0];
  assign misalign_o = misalign_reg;

  generate
    if (ADDRESS_WIDTH < 32) begin : g_pc_hi
      logic unused_pc_hi;
      assign unused_pc_hi = |fifo_head.pc[31:ADDRESS_WIDTH];
    end
  endgenerate

  // Run/halt FSM, fetch PC sequencing, redirect handling and sticky misalign.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= RUN;
      fetch_pc_reg <= ADDRESS_WIDTH'(RESET_PC);
      misalign_reg <= 1'b0;
    end else begin
      state_reg <= halt_i ? HALTED : RUN;
      if (redirect_i) begin
        fetch_pc_reg <= {redirect_pc_i[ADDRESS_WIDTH-1:2], 2'b00};
        if (redirect_pc_i[1:0] != 2'b00) begin
          misalign_reg <= 1'b1;
        end
      end else if (push) begin
        fetch_pc_reg <= fetch_pc_reg + ADDRESS_WIDTH'(PC_STEP);
      end
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .pop  (pop),
    .flush(redirect_i),
    .din  (fifo_din),
    .full (fifo_full),
    .empty(fifo_empty),
    .head (fifo_head)
  );

endmodule
